// File: rtl/ram_pkg.sv
// Shared FSM state type and default sizing for the RAM responder.
// Latency counter width covers READ_LATENCY values up to 15.
package ram_pkg;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_REG_COUNT  = 1024;
   localparam int LAT_CNT_W      = 4;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_READ_WAIT = 2'd1,
      ST_ACK       = 2'd2
   } state_t;
endpackage

// File: rtl/ram_array.sv
// Single-port word store: synchronous write, registered read with a resettable read register.
// One access per cycle, no backpressure; the stored words are never cleared by reset.
module ram_array
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_REG_COUNT,
   parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_we,
   input  logic                  i_rd_en,
   input  logic                  i_rd_clr,
   input  logic [AW-1:0]         i_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_dat,
   output logic [DATA_WIDTH-1:0] o_rd_dat
);
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rd_dat;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wr_dat;
      end
   end

   // Clear has priority so an out-of-range read returns zero without touching the array.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rd_dat <= '0;
      end else if (i_rd_clr) begin
         r_rd_dat <= '0;
      end else if (i_rd_en) begin
         r_rd_dat <= r_mem[i_addr];
      end
   end

   assign o_rd_dat = r_rd_dat;
endmodule

// File: rtl/ram_responder.sv
// Request/ack RAM responder: write acked 1 cycle after request, read acked READ_LATENCY cycles after.
// No queueing: requests while busy are dropped and flagged in the sticky o_req_dropped.
module ram_responder
   import ram_pkg::*;
#(
   parameter int  DATA_WIDTH         = DEF_DATA_WIDTH,
   parameter int  RAM_REGISTER_COUNT = DEF_REG_COUNT,
   parameter int  READ_LATENCY       = 2,
   localparam int AW = (RAM_REGISTER_COUNT > 1) ? $clog2(RAM_REGISTER_COUNT) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_ram_req,
   input  logic                  i_ram_write_m,
   input  logic [AW-1:0]         i_ram_data_addr,
   input  logic [DATA_WIDTH-1:0] i_ram_out_m,
   output logic [DATA_WIDTH-1:0] o_ram_in_m,
   output logic                  o_ram_ack,
   output logic                  o_ram_busy,
   output logic                  o_req_dropped
);
   state_t               r_state;
   state_t               w_next_state;
   logic [LAT_CNT_W-1:0] r_cnt;
   logic [AW-1:0]        r_addr;
   logic                 r_dropped;

   logic                 w_wr_req;
   logic                 w_rd_req;
   logic                 w_cnt_done;
   logic [AW-1:0]        w_addr;
   logic                 w_addr_ok;
   logic                 w_busy;
   logic                 w_ack;
   logic                 w_we;
   logic                 w_rd_load;

   assign w_wr_req   = (r_state == ST_IDLE) && i_ram_req && i_ram_write_m;
   assign w_rd_req   = (r_state == ST_IDLE) && i_ram_req && !i_ram_write_m;
   assign w_cnt_done = (r_state == ST_READ_WAIT) && (r_cnt == LAT_CNT_W'(1));

   // The array sees the live address while idle and the latched read address afterwards.
   assign w_addr    = (r_state == ST_IDLE) ? i_ram_data_addr : r_addr;
   assign w_addr_ok = ({1'b0, w_addr} < (AW+1)'(RAM_REGISTER_COUNT));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_wr_req || (w_rd_req && (READ_LATENCY == 1))) begin
               w_next_state = ST_ACK;
            end else if (w_rd_req) begin
               w_next_state = ST_READ_WAIT;
            end
         end
         ST_READ_WAIT: begin
            if (w_cnt_done) begin
               w_next_state = ST_ACK;
            end
         end
         ST_ACK:  w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_busy    = 1'b0;
      w_ack     = 1'b0;
      w_we      = 1'b0;
      w_rd_load = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_we      = w_wr_req && w_addr_ok && !i_reset;
            w_rd_load = w_rd_req && (READ_LATENCY == 1);
         end
         ST_READ_WAIT: begin
            w_busy    = 1'b1;
            w_rd_load = w_cnt_done;
         end
         ST_ACK: begin
            w_busy = 1'b1;
            w_ack  = 1'b1;
         end
         default: begin
            w_busy = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt     <= '0;
         r_addr    <= '0;
         r_dropped <= 1'b0;
      end else begin
         if (w_rd_req) begin
            r_cnt  <= LAT_CNT_W'(READ_LATENCY - 1);
            r_addr <= i_ram_data_addr;
         end else if (r_state == ST_READ_WAIT) begin
            r_cnt <= r_cnt - LAT_CNT_W'(1);
         end
         if (i_ram_req && w_busy) begin
            r_dropped <= 1'b1;
         end
      end
   end

   ram_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (RAM_REGISTER_COUNT),
      .AW         (AW)
   ) u_array (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_we     (w_we),
      .i_rd_en  (w_rd_load),
      .i_rd_clr (w_rd_load && !w_addr_ok),
      .i_addr   (w_addr),
      .i_wr_dat (i_ram_out_m),
      .o_rd_dat (o_ram_in_m)
   );

   assign o_ram_ack     = w_ack;
   assign o_ram_busy    = w_busy;
   assign o_req_dropped = r_dropped;
endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: default build plus READ_LATENCY=1, READ_LATENCY=4 and
// RAM_REGISTER_COUNT=1000 builds driven from shared address/data lines with separate strobes.
module tb_ram_responder;
   logic        clk;
   logic        reset;
   logic        we;
   logic [9:0]  addr;
   logic [15:0] wdat;
   logic        req_a, req_1, req_4, req_c;

   logic [15:0] a_in, l1_in, l4_in, c_in;
   logic        a_ack, a_busy, a_drop;
   logic        l1_ack, l1_busy, l1_drop;
   logic        l4_ack, l4_busy, l4_drop;
   logic        c_ack, c_busy, c_drop;

   int n_chk  = 0;
   int n_fail = 0;

   ram_responder u_a (
      .i_clk(clk), .i_reset(reset), .i_ram_req(req_a), .i_ram_write_m(we),
      .i_ram_data_addr(addr), .i_ram_out_m(wdat), .o_ram_in_m(a_in),
      .o_ram_ack(a_ack), .o_ram_busy(a_busy), .o_req_dropped(a_drop)
   );

   ram_responder #(.READ_LATENCY(1)) u_l1 (
      .i_clk(clk), .i_reset(reset), .i_ram_req(req_1), .i_ram_write_m(we),
      .i_ram_data_addr(addr), .i_ram_out_m(wdat), .o_ram_in_m(l1_in),
      .o_ram_ack(l1_ack), .o_ram_busy(l1_busy), .o_req_dropped(l1_drop)
   );

   ram_responder #(.READ_LATENCY(4)) u_l4 (
      .i_clk(clk), .i_reset(reset), .i_ram_req(req_4), .i_ram_write_m(we),
      .i_ram_data_addr(addr), .i_ram_out_m(wdat), .o_ram_in_m(l4_in),
      .o_ram_ack(l4_ack), .o_ram_busy(l4_busy), .o_req_dropped(l4_drop)
   );

   ram_responder #(.RAM_REGISTER_COUNT(1000)) u_c (
      .i_clk(clk), .i_reset(reset), .i_ram_req(req_c), .i_ram_write_m(we),
      .i_ram_data_addr(addr), .i_ram_out_m(wdat), .o_ram_in_m(c_in),
      .o_ram_ack(c_ack), .o_ram_busy(c_busy), .o_req_dropped(c_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled and inputs changed 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic [9:0] ad, input logic [15:0] d);
      we   = w;
      addr = ad;
      wdat = d;
   endtask

   task automatic wr_a(input logic [9:0] ad, input logic [15:0] d, input string tag);
      drive(1'b1, ad, d);
      req_a = 1'b1;
      step();
      req_a = 1'b0;
      chk({tag, "_ack"}, a_ack, 1);
      step();
      chk({tag, "_idle"}, a_ack, 0);
   endtask

   task automatic rd_a(input logic [9:0] ad, input logic [15:0] exp, input string tag);
      drive(1'b0, ad, 16'h0);
      req_a = 1'b1;
      step();
      req_a = 1'b0;
      chk({tag, "_wait"}, {a_busy, a_ack}, 2'b10);
      step();
      chk({tag, "_ack"}, a_ack, 1);
      chk({tag, "_dat"}, a_in, exp);
      step();
   endtask

   initial begin
      reset = 1'b1;
      req_a = 1'b0; req_1 = 1'b0; req_4 = 1'b0; req_c = 1'b0;
      drive(1'b0, 10'd0, 16'h0);
      step();
      // Request presented together with reset must be ignored.
      drive(1'b0, 10'd5, 16'h0);
      req_a = 1'b1;
      step();
      reset = 1'b0;
      req_a = 1'b0;
      chk("rst_ack",  a_ack,  0);
      chk("rst_busy", a_busy, 0);
      chk("rst_in",   a_in,   0);
      chk("rst_drop", a_drop, 0);
      step();
      chk("rst_req_ignored", {a_busy, a_ack}, 2'b00);

      // Write 0x1234 @5 then read it back at latency 2.
      drive(1'b1, 10'd5, 16'h1234);
      req_a = 1'b1;
      step();
      req_a = 1'b0;
      chk("wr5_ack",  a_ack,  1);
      chk("wr5_busy", a_busy, 1);
      chk("wr5_in_unchanged", a_in, 0);
      step();
      chk("wr5_idle", {a_busy, a_ack}, 2'b00);
      rd_a(10'd5, 16'h1234, "rd5");
      chk("rd5_hold_ack", a_ack, 0);
      chk("rd5_hold_dat", a_in, 16'h1234);

      // Second request during READ_WAIT is dropped and flagged.
      wr_a(10'd6, 16'h6666, "wr6");
      chk("wr_keeps_in", a_in, 16'h1234);
      drive(1'b0, 10'd6, 16'h0);
      req_a = 1'b1;
      step();
      drive(1'b1, 10'd5, 16'hFFFF);
      step();
      req_a = 1'b0;
      chk("drop_ack",  a_ack,  1);
      chk("drop_dat",  a_in,   16'h6666);
      chk("drop_flag", a_drop, 1);
      step();
      chk("drop_single_ack", {a_busy, a_ack}, 2'b00);
      chk("drop_sticky", a_drop, 1);
      rd_a(10'd5, 16'h1234, "drop_nowrite");
      chk("drop_sticky2", a_drop, 1);

      // Reset during READ_WAIT abandons the read; array keeps its contents.
      wr_a(10'd7, 16'hA5A5, "wr7");
      drive(1'b0, 10'd6, 16'h0);
      req_a = 1'b1;
      step();
      req_a = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst_ack",  a_ack,  0);
      chk("midrst_busy", a_busy, 0);
      chk("midrst_in",   a_in,   0);
      chk("midrst_drop", a_drop, 0);
      step();
      chk("midrst_no_ghost", {a_busy, a_ack}, 2'b00);
      rd_a(10'd7, 16'hA5A5, "rd7");

      // Back-to-back writes every second cycle, then readback.
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 10'(i), 16'hC000 + 16'(i * 16'h0111));
         req_a = 1'b1;
         step();
         req_a = 1'b0;
         chk($sformatf("bb_wr%0d_ack", i), a_ack, 1);
         step();
         chk($sformatf("bb_wr%0d_gap", i), a_ack, 0);
      end
      for (int i = 0; i < 16; i++) begin
         rd_a(10'(i), 16'hC000 + 16'(i * 16'h0111), $sformatf("bb_rd%0d", i));
      end

      // READ_LATENCY 1 and 4 builds, driven together.
      drive(1'b1, 10'd3, 16'h0F0F);
      req_1 = 1'b1; req_4 = 1'b1;
      step();
      req_1 = 1'b0; req_4 = 1'b0;
      chk("l1_wr_ack", l1_ack, 1);
      chk("l4_wr_ack", l4_ack, 1);
      step();
      drive(1'b0, 10'd3, 16'h0);
      req_1 = 1'b1; req_4 = 1'b1;
      step();
      req_1 = 1'b0; req_4 = 1'b0;
      chk("l1_rd_ack",  {l1_busy, l1_ack}, 2'b11);
      chk("l1_rd_dat",  l1_in, 16'h0F0F);
      chk("l4_rd_n1",   {l4_busy, l4_ack}, 2'b10);
      step();
      chk("l1_rd_idle", {l1_busy, l1_ack}, 2'b00);
      chk("l4_rd_n2",   {l4_busy, l4_ack}, 2'b10);
      step();
      chk("l4_rd_n3",   {l4_busy, l4_ack}, 2'b10);
      step();
      chk("l4_rd_n4",   {l4_busy, l4_ack}, 2'b11);
      chk("l4_rd_dat",  l4_in, 16'h0F0F);
      step();
      chk("l4_rd_idle", {l4_busy, l4_ack}, 2'b00);

      // RAM_REGISTER_COUNT=1000: in-range read first, then out-of-range write/read.
      drive(1'b1, 10'd10, 16'h5555);
      req_c = 1'b1;
      step();
      req_c = 1'b0;
      chk("c_wr10_ack", c_ack, 1);
      step();
      drive(1'b0, 10'd10, 16'h0);
      req_c = 1'b1;
      step();
      req_c = 1'b0;
      step();
      chk("c_rd10_ack", c_ack, 1);
      chk("c_rd10_dat", c_in, 16'h5555);
      step();
      drive(1'b1, 10'd1010, 16'hBEEF);
      req_c = 1'b1; req_a = 1'b1;
      step();
      req_c = 1'b0; req_a = 1'b0;
      chk("c_oor_wr_ack", c_ack, 1);
      chk("a_1010_wr_ack", a_ack, 1);
      step();
      drive(1'b0, 10'd1010, 16'h0);
      req_c = 1'b1; req_a = 1'b1;
      step();
      req_c = 1'b0; req_a = 1'b0;
      chk("c_oor_rd_wait", {c_busy, c_ack}, 2'b10);
      step();
      chk("c_oor_rd_ack", c_ack, 1);
      chk("c_oor_rd_dat", c_in, 16'h0000);
      chk("a_1010_rd_ack", a_ack, 1);
      chk("a_1010_rd_dat", a_in, 16'hBEEF);
      step();
      chk("c_oor_idle", {c_busy, c_ack}, 2'b00);
      chk("l_builds_no_drop", {l1_drop, l4_drop, c_drop}, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of every data word.
REQ-002 Parameter RAM_REGISTER_COUNT, default 1024, number of stored words; address width AW = $clog2(RAM_REGISTER_COUNT).
REQ-003 Parameter READ_LATENCY, default 2, cycles from read request to ram_ack; legal range 1..15.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ram_req  input  1  request strobe from initiator; sampled only in IDLE.
REQ-007 ram_write_m  input  1  1 = write request, 0 = read request; qualified by ram_req.
REQ-008 ram_data_addr  input  AW  word address; qualified by ram_req.
REQ-009 ram_out_m  input  DATA_WIDTH  write data from initiator; qualified by ram_req && ram_write_m.
REQ-010 ram_in_m  output  DATA_WIDTH  read data to initiator; valid when ram_ack=1 after a read.
REQ-011 ram_ack  output  1  one-cycle completion pulse, one per accepted request.
REQ-012 ram_busy  output  1  1 while a request is in progress; initiator must not assert ram_req then.
REQ-013 req_dropped  output  1  sticky flag, set when ram_req is seen while ram_busy=1.

Function
REQ-014 FSM states: IDLE, READ_WAIT, ACK.
REQ-015 IDLE: ram_busy=0, ram_ack=0; ram_req with ram_write_m=1 -> array written at that edge, go ACK.
REQ-016 IDLE: ram_req with ram_write_m=0 -> latch address, load wait counter with READ_LATENCY-1; go ACK if READ_LATENCY=1, else READ_WAIT.
REQ-017 READ_WAIT: counter decrements each cycle; at 1 -> go ACK with read data registered to ram_in_m at that edge.
REQ-018 ACK: ram_ack=1, ram_busy=1 for exactly one cycle, then IDLE unconditionally; ram_req in ACK is not accepted.
REQ-019 Write latency: ram_ack exactly 1 cycle after the request cycle; read latency: exactly READ_LATENCY cycles after the request cycle.
REQ-020 Maximum throughput: one request per 2 cycles (writes), one per READ_LATENCY+1 cycles (reads).
REQ-021 ram_in_m holds the last read value until the next read completes; writes do not change ram_in_m.
REQ-022 Read of an address written by an earlier acknowledged write returns the new data.
REQ-023 Address >= RAM_REGISTER_COUNT: write discarded, read returns 0; both still acknowledged at normal latency.
REQ-024 ram_req while ram_busy=1 (READ_WAIT or ACK): request ignored, req_dropped set to 1, in-progress transaction unaffected.
REQ-025 Inputs other than ram_req are don't-care when ram_req=0 or the block is busy.

Reset
REQ-026 While reset=1 at a clock edge: state -> IDLE, counter -> 0, ram_ack -> 0, ram_busy -> 0, ram_in_m -> 0, req_dropped -> 0.
REQ-027 Reset mid-transaction abandons it; no ram_ack is issued for it; a write already accepted in IDLE stays in the array.
REQ-028 Array contents are not cleared by reset.
REQ-029 ram_req asserted in the same cycle as reset is ignored.

Structure
REQ-030 Shared package ram_pkg holds the FSM state enum typedef and default DATA_WIDTH/RAM_REGISTER_COUNT constants.
REQ-031 Storage is a sub-module ram_array (single-port, synchronous write, registered read, DATA_WIDTH x RAM_REGISTER_COUNT).
REQ-032 FSM, latency counter, out-of-range check and req_dropped logic live in ram_responder.

Verification
REQ-033 Write 0x1234 at addr 5, then read addr 5 (READ_LATENCY=2) -> ack 1 cycle after write; ack 2 cycles after read with ram_in_m=0x1234.
REQ-034 READ_LATENCY=1 and READ_LATENCY=4 builds: read request at cycle N -> ram_ack only at N+1 / N+4 respectively, ram_busy=1 from N+1 through the ack cycle.
REQ-035 Read issued, second ram_req issued during READ_WAIT -> req_dropped=1, one ack only, data of first read; req_dropped stays 1 until reset.
REQ-036 RAM_REGISTER_COUNT=1000: write 0xBEEF at addr 1010, read addr 1010 -> both acked, ram_in_m=0x0000.
REQ-037 Reset asserted in READ_WAIT -> no ack, all outputs 0 next cycle; then read of previously written addr 7 (0xA5A5) -> 0xA5A5.
REQ-038 Back-to-back writes to addrs 0..15 each issued in the first IDLE cycle -> 16 acks at every 2nd cycle, readback matches all 16.
